// File: rtl/core_mem_pkg.sv
// Shared constants, status layout and region decode for the core data-memory responder.
package core_mem_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BYTE_W = 8;

  // MMIO register offsets within the 16-byte page
  localparam logic [3:0] MMIO_CYCLE  = 4'h0;
  localparam logic [3:0] MMIO_TXDATA = 4'h4;
  localparam logic [3:0] MMIO_STATUS = 4'h8;
  localparam logic [3:0] MMIO_LED    = 4'hC;

  localparam int unsigned STAT_OVF   = 31;
  localparam int unsigned STAT_AERR  = 30;
  localparam int unsigned STAT_EMPTY = 17;
  localparam int unsigned STAT_FULL  = 16;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_MMIO,
    REG_NONE
  } region_e;

  typedef struct packed {
    logic        ovf;
    logic        aerr;
    logic [11:0] rsvd_hi;
    logic        empty;
    logic        full;
    logic [7:0]  rsvd_lo;
    logic [7:0]  count;
  } status_t;

  // RAM takes priority; the MMIO page is matched on the upper 28 address bits
  function automatic region_e decode_region(input logic [31:0] word_addr,
                                            input logic [31:0] ram_bytes,
                                            input logic [27:0] mmio_page);
    if (word_addr < ram_bytes) return REG_RAM;
    if (word_addr[31:4] == mmio_page) return REG_MMIO;
    return REG_NONE;
  endfunction

endpackage

// File: rtl/core_data_responder_if.sv
// Core data-memory port plus console byte stream between the core side and the responder.
interface core_data_responder_if;

  logic [31:0] data_address;
  logic [31:0] write_data;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] read_data;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;

  modport master (
    output data_address, write_data, mem_write, mem_read, tx_ready,
    input  read_data, tx_valid, tx_data
  );

  modport slave (
    input  data_address, write_data, mem_write, mem_read, tx_ready,
    output read_data, tx_valid, tx_data
  );

endinterface

// File: rtl/core_data_responder_byte_fifo.sv
// Byte FIFO with wrap-bit pointers; a pop frees a slot for a same-cycle push when full.
module byte_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [7:0]             push_data,
  input  logic                   pop,
  output logic [7:0]             head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wptr_q;
  logic [AW:0] rptr_q;
  logic        do_push;
  logic        do_pop;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign count   = wptr_q - rptr_q;
  // Gate the head so stale storage never shows up while empty
  assign head    = empty ? 8'h00 : mem[rptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
      if (do_pop)  rptr_q <= rptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/core_data_responder.sv
// Data-memory responder: RAM, cycle counter, LED register and console TX FIFO behind one port.
module core_data_responder
  import core_mem_pkg::*;
#(
  parameter int unsigned RAM_WORDS  = 1024,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  core_data_responder_if.slave  bus,
  output logic [7:0]            led
);

  localparam int unsigned RAM_AW    = $clog2(RAM_WORDS);
  localparam int unsigned FIFO_CW   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

  logic [31:0]       ram [RAM_WORDS];
  logic [31:0]       word_addr;
  logic [3:0]        mmio_off;
  logic [RAM_AW-1:0] ram_idx;
  region_e           region;

  logic [31:0] cycle_q;
  logic [7:0]  led_q;
  logic        ovf_q;
  logic        aerr_q;

  logic ram_we, led_we, status_we, push, pop;
  logic ovf_set, aerr_set, ovf_clr, aerr_clr;
  logic fifo_full, fifo_empty;
  logic [7:0]         fifo_head;
  logic [FIFO_CW-1:0] fifo_count;
  status_t            status;
  logic [31:0]        rdata;
  logic               unused_bits;

  assign word_addr = {bus.data_address[31:2], 2'b00};
  assign mmio_off  = word_addr[3:0];
  assign ram_idx   = bus.data_address[RAM_AW+1:2];
  assign region    = decode_region(word_addr, RAM_BYTES, MMIO_BASE[31:4]);
  assign unused_bits = ^{bus.data_address[1:0], bus.write_data[29:8]};

  // Store strobes per target
  always_comb begin
    ram_we    = 1'b0;
    led_we    = 1'b0;
    status_we = 1'b0;
    push      = 1'b0;
    case (region)
      REG_RAM:  ram_we = bus.mem_write;
      REG_MMIO: begin
        case (mmio_off)
          MMIO_TXDATA: push      = bus.mem_write;
          MMIO_STATUS: status_we = bus.mem_write;
          MMIO_LED:    led_we    = bus.mem_write;
          default:     ;
        endcase
      end
      default: ;
    endcase
  end

  assign pop      = !fifo_empty && bus.tx_ready;
  // A full push only loses its byte when no pop frees a slot this cycle
  assign ovf_set  = push && fifo_full && !pop;
  assign aerr_set = (region == REG_NONE) && (bus.mem_read || bus.mem_write);
  assign ovf_clr  = status_we && bus.write_data[STAT_OVF];
  assign aerr_clr = status_we && bus.write_data[STAT_AERR];

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (bus.write_data[7:0]),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bus.tx_valid = !fifo_empty;
  assign bus.tx_data  = fifo_head;
  assign led          = led_q;

  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_idx] <= bus.write_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q <= '0;
      led_q   <= '0;
      ovf_q   <= 1'b0;
      aerr_q  <= 1'b0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      if (led_we) led_q <= bus.write_data[7:0];
      // Set beats a same-cycle write-one-to-clear
      if (ovf_set)      ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
      if (aerr_set)      aerr_q <= 1'b1;
      else if (aerr_clr) aerr_q <= 1'b0;
    end
  end

  always_comb begin
    status       = '0;
    status.ovf   = ovf_q;
    status.aerr  = aerr_q;
    status.empty = fifo_empty;
    status.full  = fifo_full;
    status.count = 8'(fifo_count);
  end

  // Load path reflects state before the current edge
  always_comb begin
    rdata = '0;
    if (bus.mem_read) begin
      case (region)
        REG_RAM:  rdata = ram[ram_idx];
        REG_MMIO: begin
          case (mmio_off)
            MMIO_CYCLE:  rdata = cycle_q;
            MMIO_STATUS: rdata = status;
            MMIO_LED:    rdata = 32'(led_q);
            default:     rdata = '0;
          endcase
        end
        default: rdata = '0;
      endcase
    end
  end

  assign bus.read_data = rdata;

endmodule

// File: tb/tb_core_data_responder.sv
// Self-checking bench: directed vector table, multi-cycle FIFO/reset sequences, random traffic vs model.
module tb_core_data_responder;

  localparam int unsigned RAM_WORDS  = 1024;
  localparam int unsigned FIFO_DEPTH = 8;
  localparam logic [31:0] MMIO_BASE  = 32'hFFFF_0000;

  logic       clk;
  logic       rst_n;
  logic [7:0] led;

  core_data_responder_if bus();

  core_data_responder #(
    .RAM_WORDS  (RAM_WORDS),
    .FIFO_DEPTH (FIFO_DEPTH),
    .MMIO_BASE  (MMIO_BASE)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .led   (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state
  logic [31:0] m_cycle;
  logic [31:0] m_ram [int];
  logic [7:0]  m_q [$];
  logic [7:0]  m_led;
  logic        m_ovf;
  logic        m_aerr;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic [31:0] exp_rd;
    string       name;
  } vec_t;

  vec_t tbl [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, act, exp);
    end
  endtask

  function automatic void m_reset();
    m_cycle = 0;
    m_q.delete();
    m_led  = 8'h00;
    m_ovf  = 1'b0;
    m_aerr = 1'b0;
  endfunction

  // 0 = RAM, 1 = MMIO page, 2 = unmapped
  function automatic int m_region(input logic [31:0] addr);
    logic [31:0] a;
    a = addr & 32'hFFFF_FFFC;
    if (a < RAM_WORDS * 4) return 0;
    if ((a >> 4) == (MMIO_BASE >> 4)) return 1;
    return 2;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] addr, input logic re);
    int          r;
    int          off;
    logic [31:0] st;
    if (!re) return 32'h0;
    r   = m_region(addr);
    off = int'(addr & 32'hC);
    if (r == 0) return m_ram[int'(addr >> 2)];
    if (r == 2) return 32'h0;
    if (off == 0) return m_cycle;
    if (off == 8) begin
      st = 32'(m_q.size());
      if (m_q.size() == 0) st = st + 32'h0002_0000;
      if (m_q.size() == FIFO_DEPTH) st = st + 32'h0001_0000;
      if (m_aerr) st = st + 32'h4000_0000;
      if (m_ovf) st = st + 32'h8000_0000;
      return st;
    end
    if (off == 12) return 32'(m_led);
    return 32'h0;
  endfunction

  task automatic m_edge(input logic [31:0] addr, input logic [31:0] wdata,
                        input logic we, input logic re, input logic rdy);
    int r;
    int off;
    bit pop;
    bit push;
    bit ovf_set;
    r       = m_region(addr);
    off     = int'(addr & 32'hC);
    pop     = (m_q.size() != 0) && rdy;
    push    = we && (r == 1) && (off == 4);
    ovf_set = push && (m_q.size() == FIFO_DEPTH) && !pop;
    if (we && r == 1 && off == 8) begin
      if (wdata[31]) m_ovf = 1'b0;
      if (wdata[30]) m_aerr = 1'b0;
    end
    if (ovf_set) m_ovf = 1'b1;
    if ((we || re) && r == 2) m_aerr = 1'b1;
    if (pop) void'(m_q.pop_front());
    if (push && !ovf_set) m_q.push_back(wdata[7:0]);
    if (we && r == 0) m_ram[int'(addr >> 2)] = wdata;
    if (we && r == 1 && off == 12) m_led = wdata[7:0];
    m_cycle = m_cycle + 32'd1;
  endtask

  // Starts and ends on a falling edge; checks all outputs against the model before the rising edge
  task automatic do_cycle(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic we, input logic re, input logic rdy,
                          output logic [31:0] rd, output logic txv, output logic [7:0] txd);
    bus.data_address = addr;
    bus.write_data   = wdata;
    bus.mem_write    = we;
    bus.mem_read     = re;
    bus.tx_ready     = rdy;
    #1;
    rd  = bus.read_data;
    txv = bus.tx_valid;
    txd = bus.tx_data;
    chk("model_read_data", rd, m_read(addr, re));
    chk("model_tx_valid", 32'(txv), (m_q.size() != 0) ? 32'd1 : 32'd0);
    chk("model_tx_data", 32'(txd), (m_q.size() != 0) ? 32'(m_q[0]) : 32'd0);
    chk("model_led", 32'(led), 32'(m_led));
    @(posedge clk);
    m_edge(addr, wdata, we, re, rdy);
    @(negedge clk);
  endtask

  logic [31:0] rd;
  logic        txv;
  logic [7:0]  txd;
  logic [7:0]  drain_exp [8];

  initial begin
    rst_n            = 1'b0;
    bus.data_address = 32'h0;
    bus.write_data   = 32'h0;
    bus.mem_write    = 1'b0;
    bus.mem_read     = 1'b0;
    bus.tx_ready     = 1'b0;

    tbl[0]  = '{32'hFFFF_0000, 32'h0,         1'b0, 1'b1, 32'h0000_0000, "cycle_at_0"};
    tbl[1]  = '{32'hFFFF_0000, 32'h0,         1'b0, 1'b0, 32'h0000_0000, "idle_gated_1"};
    tbl[2]  = '{32'hFFFF_0000, 32'h0,         1'b0, 1'b0, 32'h0000_0000, "idle_gated_2"};
    tbl[3]  = '{32'hFFFF_0000, 32'h0,         1'b0, 1'b0, 32'h0000_0000, "idle_gated_3"};
    tbl[4]  = '{32'hFFFF_0000, 32'h0,         1'b0, 1'b0, 32'h0000_0000, "idle_gated_4"};
    tbl[5]  = '{32'hFFFF_0000, 32'h0,         1'b0, 1'b1, 32'h0000_0005, "cycle_at_5"};
    tbl[6]  = '{32'hFFFF_0008, 32'h0,         1'b0, 1'b1, 32'h0002_0000, "status_reset"};
    tbl[7]  = '{32'hFFFF_000C, 32'h0,         1'b0, 1'b1, 32'h0000_0000, "led_reset"};
    tbl[8]  = '{32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0000_0000, "ram_store"};
    tbl[9]  = '{32'h0000_0010, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF, "ram_load"};
    tbl[10] = '{32'h0000_0013, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF, "ram_load_unaligned"};
    tbl[11] = '{32'h8000_0000, 32'h0,         1'b0, 1'b1, 32'h0000_0000, "unmapped_load"};
    tbl[12] = '{32'hFFFF_0008, 32'h0,         1'b0, 1'b1, 32'h4002_0000, "status_aerr"};
    tbl[13] = '{32'hFFFF_0008, 32'h4000_0000, 1'b1, 1'b1, 32'h4002_0000, "status_clr_old"};
    tbl[14] = '{32'hFFFF_0008, 32'h0,         1'b0, 1'b1, 32'h0002_0000, "status_cleared"};
    tbl[15] = '{32'hFFFF_000C, 32'h0000_01A5, 1'b1, 1'b0, 32'h0000_0000, "led_store"};
    tbl[16] = '{32'hFFFF_000C, 32'h0,         1'b0, 1'b1, 32'h0000_00A5, "led_load"};
    tbl[17] = '{32'hFFFF_0004, 32'h0,         1'b0, 1'b1, 32'h0000_0000, "txdata_reads_0"};

    repeat (2) @(negedge clk);
    m_reset();
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      do_cycle(tbl[i].addr, tbl[i].wdata, tbl[i].we, tbl[i].re, 1'b0, rd, txv, txd);
      chk(tbl[i].name, rd, tbl[i].exp_rd);
    end
    chk("led_port", 32'(led), 32'h0000_00A5);

    // FIFO ordering: A, B, C held then drained
    for (int i = 0; i < 3; i++)
      do_cycle(32'hFFFF_0004, 32'h41 + 32'(i), 1'b1, 1'b0, 1'b0, rd, txv, txd);
    do_cycle(32'hFFFF_0008, 32'h0, 1'b0, 1'b1, 1'b0, rd, txv, txd);
    chk("abc_status", rd, 32'h0000_0003);
    chk("abc_head", 32'(txd), 32'h41);
    for (int k = 0; k < 3; k++) begin
      do_cycle(32'h0, 32'h0, 1'b0, 1'b0, 1'b1, rd, txv, txd);
      chk("abc_drain_valid", 32'(txv), 32'h1);
      chk("abc_drain_byte", 32'(txd), 32'h41 + 32'(k));
    end
    do_cycle(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, rd, txv, txd);
    chk("abc_empty_valid", 32'(txv), 32'h0);

    // Overflow, then push+pop on a full FIFO
    for (int i = 0; i < 9; i++)
      do_cycle(32'hFFFF_0004, 32'h30 + 32'(i), 1'b1, 1'b0, 1'b0, rd, txv, txd);
    do_cycle(32'hFFFF_0008, 32'h0, 1'b0, 1'b1, 1'b0, rd, txv, txd);
    chk("ovf_status", rd, 32'h8001_0008);
    do_cycle(32'hFFFF_0004, 32'h99, 1'b1, 1'b0, 1'b1, rd, txv, txd);
    chk("full_pushpop_head", 32'(txd), 32'h30);
    do_cycle(32'hFFFF_0008, 32'h0, 1'b0, 1'b1, 1'b0, rd, txv, txd);
    chk("full_pushpop_status", rd, 32'h8001_0008);
    chk("full_pushpop_newhead", 32'(txd), 32'h31);
    do_cycle(32'hFFFF_0008, 32'h8000_0000, 1'b1, 1'b0, 1'b0, rd, txv, txd);
    drain_exp = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h99};
    for (int k = 0; k < 8; k++) begin
      do_cycle(32'h0, 32'h0, 1'b0, 1'b0, 1'b1, rd, txv, txd);
      chk("ovf_drain_byte", 32'(txd), 32'(drain_exp[k]));
    end
    do_cycle(32'hFFFF_0008, 32'h0, 1'b0, 1'b1, 1'b0, rd, txv, txd);
    chk("ovf_cleared_status", rd, 32'h0002_0000);

    // Reset asserted mid-drain
    for (int i = 0; i < 5; i++)
      do_cycle(32'hFFFF_0004, 32'h50 + 32'(i), 1'b1, 1'b0, 1'b0, rd, txv, txd);
    do_cycle(32'h0, 32'h0, 1'b0, 1'b0, 1'b1, rd, txv, txd);
    #1;
    chk("pre_reset_valid", 32'(bus.tx_valid), 32'h1);
    chk("pre_reset_head", 32'(bus.tx_data), 32'h51);
    #1;
    rst_n = 1'b0;
    #1;
    chk("reset_valid_drop", 32'(bus.tx_valid), 32'h0);
    chk("reset_tx_data", 32'(bus.tx_data), 32'h0);
    chk("reset_led", 32'(led), 32'h0);
    m_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_cycle(32'hFFFF_0000, 32'h0, 1'b0, 1'b1, 1'b0, rd, txv, txd);
    chk("cycle_restart_0", rd, 32'h0);
    do_cycle(32'hFFFF_0008, 32'h0, 1'b0, 1'b1, 1'b0, rd, txv, txd);
    chk("post_reset_status", rd, 32'h0002_0000);
    do_cycle(32'hFFFF_0000, 32'h0, 1'b0, 1'b1, 1'b0, rd, txv, txd);
    chk("cycle_restart_2", rd, 32'h2);

    // Known RAM contents for random traffic
    for (int w = 0; w < 64; w++)
      do_cycle(32'(w) << 2, $urandom, 1'b1, 1'b0, 1'b0, rd, txv, txd);

    for (int n = 0; n < 500; n++) begin
      logic [31:0] a;
      int          kind;
      kind = int'($urandom_range(0, 9));
      if (kind <= 4)
        a = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
      else if (kind <= 7)
        a = MMIO_BASE + (32'($urandom_range(0, 3)) << 2) + 32'($urandom_range(0, 3));
      else if (kind == 8)
        a = ($urandom_range(0, 1) == 0) ? 32'hFFFF_0010 : (32'h0001_0000 | 32'($urandom_range(0, 255)));
      else
        a = 32'h0000_1000 | 32'($urandom_range(0, 3));
      do_cycle(a, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 3) == 0), rd, txv, txd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/core_data_responder.md
# core_data_responder

Responder for the pipeline core's data-memory port: accepts `data_address`/`write_data`/`mem_write`/`mem_read` from the core and returns `read_data` in the same cycle. It holds the data RAM plus a small MMIO page: a free-running cycle counter, an LED register, and a console TX FIFO that drains over a valid/ready byte stream. It sits at `core` level, beside the instruction memory, and closes the core's data interface.

## Interface
- `RAM_WORDS`, 1024: RAM depth in 32-bit words; power of two.
- `FIFO_DEPTH`, 8: console FIFO depth in bytes; power of two, 2..128.
- `MMIO_BASE`, 32'hFFFF_0000: base address of the MMIO page.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `data_address` in 32: byte address from the core; bits [1:0] ignored.
- `write_data` in 32: store data.
- `mem_write` in 1: store strobe, applied at the rising edge.
- `mem_read` in 1: load strobe, qualifies `read_data`.
- `read_data` out 32: load data, combinational from current address and state.
- `tx_valid` out 1: a console byte is available.
- `tx_data` out 8: head byte of the FIFO.
- `tx_ready` in 1: the console sink accepts the byte.
- `led` out 8: LED register.

## Operation
- Decode on word address `A = data_address & ~3`:
  - RAM when `A < RAM_WORDS*4`.
  - MMIO when `A[31:4] == MMIO_BASE[31:4]`.
  - Otherwise unmapped.
- MMIO map, as offsets from `MMIO_BASE`:
  - 0x0 CYCLE (RO): 32-bit counter. +1 every cycle after reset, wraps 0xFFFF_FFFF→0.
  - 0x4 TXDATA (WO): a store pushes `write_data[7:0]`. Reads return 0.
  - 0x8 STATUS (RW1C): [31] overflow sticky, [30] addr_err sticky, [17] empty, [16] full, [7:0] count, others 0. A store with bit 31 or 30 set clears that sticky bit.
  - 0xC LED (RW): [7:0] only. Reads return zero-extended.
- `read_data` is 0 when `mem_read`=0 or the address is unmapped. Otherwise it is the addressed word/register as it stands before the current edge.
- Store to unmapped space: ignored, sets addr_err. A load from unmapped space also sets addr_err.
- `mem_read` and `mem_write` both high: the load returns the old value, and the store commits at the edge.
- FIFO:
  - `tx_valid` = !empty; `tx_data` = head.
  - Pop when `tx_valid && tx_ready` at the edge.
  - A push to a full FIFO is dropped and sets overflow, unless a pop occurs in the same cycle, in which case the push is accepted and count is unchanged.
  - Push and pop together on a non-full, non-empty FIFO: count unchanged.
  - Push while empty: the byte appears on `tx_data` the next cycle.
- Sticky set and RW1C clear in the same cycle: set wins.

## Timing
- Loads: zero-latency combinational path. Stores, pushes, pops and counter updates: one edge.
- Reset values (asynchronous, immediate on `rst_n` low):
  - CYCLE=0, LED=0, FIFO empty, count=0, sticky bits=0, `tx_valid`=0, `tx_data`=0.
  - RAM is not reset.
- First cycle after release: CYCLE reads 0, then increments.
- Reset asserted mid-drain: FIFO contents are discarded, and `tx_valid` drops the same instant.
- `tx_data` is held stable while `tx_valid && !tx_ready`.

## Structure
- Package `core_mem_pkg`: MMIO offset constants (`MMIO_CYCLE`, `MMIO_TXDATA`, `MMIO_STATUS`, `MMIO_LED`), STATUS bit positions, and the region enum `{REG_RAM, REG_MMIO, REG_NONE}`.
- Sub-module `byte_fifo`, parameterised by depth:
  - Pointers carry one extra wrap bit; full/empty derive from them.
  - Provides push/pop/count/full/empty.
- Top level holds address decode, RAM array, counter, LED and sticky logic.

## Test plan
- After reset: load 0xFFFF_0000 returns 0, 5 cycles later returns 5. LED=0, `tx_valid`=0, STATUS=0x0002_0000.
- Store 0xDEADBEEF to 0x10 then load 0x10 returns 0xDEADBEEF. Load 0x13 also returns 0xDEADBEEF. Load 0x8000_0000 returns 0 and STATUS[30]=1. Store 0x4000_0000 to STATUS clears it.
- Push 'A','B','C' with `tx_ready`=0: count=3, `tx_data`='A'. Raise `tx_ready` for 3 cycles: bytes appear in order A, B, C, then `tx_valid`=0.
- With FIFO_DEPTH=8 and `tx_ready`=0, push 9 bytes: count=8, full=1, STATUS[31]=1, and the 9th byte is lost. Then with FIFO full, push and pop in the same cycle: push accepted, count stays 8.
- Store 0x1A5 to LED: `led`=0xA5, and a load returns 0x0000_00A5.
- Assert `rst_n` low mid-drain with 4 bytes queued: `tx_valid`=0 immediately. After release, count=0 and CYCLE restarts at 0.
